// File: rtl/mux2_arbiter.sv
// mux2_arbiter: round-robin arbiter sharing one registered 2:1 data path
// between two requesters, with a per-grant burst limit.
//
// Ports:
//   clk      - rising-edge clock
//   rst      - synchronous active-high reset
//   req1/2   - requester k wants the path (held high while it has data)
//   d1/d2    - requester data, sampled on transfer cycles
//   gnt1/2   - requester k owns the path (registered, never both high)
//   sel      - path select, 0 = d1, 1 = d2 (registered, held in IDLE)
//   f        - registered path output
//   f_valid  - f holds a word transferred on the previous edge
module mux2_arbiter #(
  parameter int unsigned W         = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req1,
  input  logic         req2,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  output logic         gnt1,
  output logic         gnt2,
  output logic         sel,
  output logic [W-1:0] f,
  output logic         f_valid
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G1   = 2'd1,
    G2   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               last2_q, last2_d;   // 1: requester 2 was granted most recently
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]       f_d;
  logic               f_valid_d;
  logic               gnt1_d, gnt2_d, sel_d;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last2_q <= 1'b1;
      cnt_q   <= '0;
      f       <= '0;
      f_valid <= 1'b0;
      gnt1    <= 1'b0;
      gnt2    <= 1'b0;
      sel     <= 1'b0;
    end else begin
      state_q <= state_d;
      last2_q <= last2_d;
      cnt_q   <= cnt_d;
      f       <= f_d;
      f_valid <= f_valid_d;
      gnt1    <= gnt1_d;
      gnt2    <= gnt2_d;
      sel     <= sel_d;
    end
  end

  // Next-state, burst counting and data-path update
  always_comb begin
    state_d   = state_q;
    last2_d   = last2_q;
    cnt_d     = cnt_q;
    f_d       = f;
    f_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req1 && (!req2 || last2_q)) begin
          state_d = G1;
          last2_d = 1'b0;
          cnt_d   = '0;
        end else if (req2) begin
          state_d = G2;
          last2_d = 1'b1;
          cnt_d   = '0;
        end
      end

      G1: begin
        if (req1) begin
          f_d       = d1;
          f_valid_d = 1'b1;
          if (cnt_q == BURST_LAST) begin
            // Burst expired: hand over if contested, otherwise restart
            cnt_d = '0;
            if (req2) begin
              state_d = G2;
              last2_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (req2) begin
          state_d = G2;
          last2_d = 1'b1;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end

      G2: begin
        if (req2) begin
          f_d       = d2;
          f_valid_d = 1'b1;
          if (cnt_q == BURST_LAST) begin
            cnt_d = '0;
            if (req1) begin
              state_d = G1;
              last2_d = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (req1) begin
          state_d = G1;
          last2_d = 1'b0;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Grant/select registers follow the next state; sel holds through IDLE
  always_comb begin
    gnt1_d = (state_d == G1);
    gnt2_d = (state_d == G2);
    sel_d  = sel;
    if (state_d == G1) sel_d = 1'b0;
    if (state_d == G2) sel_d = 1'b1;
  end

endmodule

// File: tb/tb_mux2_arbiter.sv
// Directed self-checking bench for mux2_arbiter. Two instances share the
// same stimulus: one with MAX_BURST = 4, one with MAX_BURST = 1.
module tb_mux2_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req1, req2;
  logic [7:0] d1, d2;

  logic       gnt1_a, gnt2_a, sel_a, f_valid_a;
  logic [7:0] f_a;
  logic       gnt1_b, gnt2_b, sel_b, f_valid_b;
  logic [7:0] f_b;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mux2_arbiter #(.W(8), .MAX_BURST(4)) u_b4 (
    .clk(clk), .rst(rst), .req1(req1), .req2(req2), .d1(d1), .d2(d2),
    .gnt1(gnt1_a), .gnt2(gnt2_a), .sel(sel_a), .f(f_a), .f_valid(f_valid_a)
  );

  mux2_arbiter #(.W(8), .MAX_BURST(1)) u_b1 (
    .clk(clk), .rst(rst), .req1(req1), .req2(req2), .d1(d1), .d2(d2),
    .gnt1(gnt1_b), .gnt2(gnt2_b), .sel(sel_b), .f(f_b), .f_valid(f_valid_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge; sample and drive 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req1 = 1'b0; req2 = 1'b0; d1 = '0; d2 = '0;
    step();
    step();
    check("rst_gnt1", 32'(gnt1_a), 32'd0);
    check("rst_gnt2", 32'(gnt2_a), 32'd0);
    check("rst_sel", 32'(sel_a), 32'd0);
    check("rst_f", 32'(f_a), 32'd0);
    check("rst_fv", 32'(f_valid_a), 32'd0);
    check("rst_b1_gnt1", 32'(gnt1_b), 32'd0);

    // Reset mid-burst
    rst = 1'b0; req1 = 1'b1; d1 = 8'hA5;
    step();
    check("mb_gnt1_e1", 32'(gnt1_a), 32'd1);
    check("mb_fv_e1", 32'(f_valid_a), 32'd0);
    step();
    check("mb_f_e2", 32'(f_a), 32'hA5);
    check("mb_fv_e2", 32'(f_valid_a), 32'd1);
    step();
    step();
    rst = 1'b1;
    step();
    check("mb_rst_gnt1", 32'(gnt1_a), 32'd0);
    check("mb_rst_gnt2", 32'(gnt2_a), 32'd0);
    check("mb_rst_sel", 32'(sel_a), 32'd0);
    check("mb_rst_f", 32'(f_a), 32'd0);
    check("mb_rst_fv", 32'(f_valid_a), 32'd0);

    // Tie after reset: 4-burst alternation and strict alternation
    req1 = 1'b1; req2 = 1'b1; d1 = 8'h11; d2 = 8'h22;
    step();
    rst = 1'b0;
    step();
    check("tie_gnt1_e1", 32'(gnt1_a), 32'd1);
    check("tie_sel_e1", 32'(sel_a), 32'd0);
    check("alt_gnt1_e1", 32'(gnt1_b), 32'd1);
    for (int k = 2; k <= 10; k++) begin
      step();
      check("tie_f", 32'(f_a), (k <= 5 || k >= 10) ? 32'h11 : 32'h22);
      check("tie_fv", 32'(f_valid_a), 32'd1);
      check("tie_sel", 32'(sel_a), (k >= 5 && k <= 8) ? 32'd1 : 32'd0);
      check("alt_f", 32'(f_b), (k % 2 == 0) ? 32'h11 : 32'h22);
      check("alt_fv", 32'(f_valid_b), 32'd1);
    end

    // Early release by requester 2
    rst = 1'b1; req1 = 1'b0; req2 = 1'b1;
    step();
    rst = 1'b0;
    step();
    check("er_gnt2_e1", 32'(gnt2_a), 32'd1);
    check("er_sel_e1", 32'(sel_a), 32'd1);
    step();
    check("er_f_e2", 32'(f_a), 32'h22);
    step();
    check("er_fv_e3", 32'(f_valid_a), 32'd1);
    req2 = 1'b0; req1 = 1'b1; d1 = 8'h33;
    step();
    check("er_bubble_fv", 32'(f_valid_a), 32'd0);
    check("er_bubble_f", 32'(f_a), 32'h22);
    check("er_gnt1", 32'(gnt1_a), 32'd1);
    check("er_gnt2", 32'(gnt2_a), 32'd0);
    step();
    check("er_f_d1", 32'(f_a), 32'h33);
    check("er_fv_d1", 32'(f_valid_a), 32'd1);

    // Burst restart with no competitor
    for (int i = 0; i < 10; i++) begin
      d1 = 8'(8'h40 + i);
      step();
      check("br_f", 32'(f_a), 32'(8'h40 + i));
      check("br_fv", 32'(f_valid_a), 32'd1);
      check("br_gnt1", 32'(gnt1_a), 32'd1);
    end

    // Idle return from G1
    req1 = 1'b0;
    step();
    check("id1_gnt1", 32'(gnt1_a), 32'd0);
    check("id1_gnt2", 32'(gnt2_a), 32'd0);
    check("id1_fv", 32'(f_valid_a), 32'd0);
    check("id1_f", 32'(f_a), 32'h49);

    // Idle return from G2: sel and f must hold
    req2 = 1'b1; d2 = 8'h5A;
    step();
    check("id2_gnt2", 32'(gnt2_a), 32'd1);
    step();
    check("id2_f_xfer", 32'(f_a), 32'h5A);
    req2 = 1'b0; d2 = 8'h00;
    step();
    check("id2_gnt2_off", 32'(gnt2_a), 32'd0);
    check("id2_sel_hold", 32'(sel_a), 32'd1);
    check("id2_f_hold", 32'(f_a), 32'h5A);
    check("id2_fv", 32'(f_valid_a), 32'd0);
    step();
    check("id2_sel_hold2", 32'(sel_a), 32'd1);
    check("id2_f_hold2", 32'(f_a), 32'h5A);
    check("id2_fv2", 32'(f_valid_a), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Mutual exclusion of grants on every cycle
  always @(negedge clk) begin
    if (gnt1_a && gnt2_a) begin
      tests_failed++;
      $display("FAIL gnt_excl: got gnt1=%0b gnt2=%0b expected not both", gnt1_a, gnt2_a);
    end
  end

endmodule

// File: doc/mux2_arbiter.md
# mux2_arbiter

Round-robin arbiter that shares one registered 2:1 data path between two requesters. Each requester raises a request, receives an exclusive grant, and streams words through the shared path. Its words appear on a single registered output with a valid flag. The block drives the path's select line and bounds each ownership period to a maximum burst, so neither requester can starve the other.

## Interface
- W, default 8: data width of each requester and of the output.
- MAX_BURST, default 4: maximum transfers per grant while the other side is waiting. Legal range is 1..255.
- clk, input, 1: rising-edge clock.
- rst, input, 1: synchronous, active-high reset.
- req1, input, 1: requester 1 wants the path; held high for as long as it has data.
- req2, input, 1: requester 2, same meaning as req1.
- d1, input, W: requester 1 data; sampled on each transfer cycle.
- d2, input, W: requester 2 data; sampled on each transfer cycle.
- gnt1, output, 1: requester 1 owns the path (registered).
- gnt2, output, 1: requester 2 owns the path (registered).
- sel, output, 1: path select; 0 selects d1, 1 selects d2 (registered).
- f, output, W: registered path output.
- f_valid, output, 1: f holds a word transferred in the previous cycle.

## Operation
- State machine states:
  - IDLE: gnt1 = gnt2 = 0.
  - G1: gnt1 = 1, sel = 0.
  - G2: gnt2 = 1, sel = 1.
- gnt1, gnt2 and sel are decoded from registered state. gnt1 and gnt2 are never both 1.
- The round-robin pointer `last` records the most recently granted requester. Its reset value is 2, so requester 1 wins the first tie.
- IDLE, next state:
  - req1 & req2: grant the side that is not `last`.
  - Only one request: grant that side.
  - No request: stay in IDLE.
  - On entry to G1 or G2: `last` updates and the burst counter clears to 0.
- Transfer cycle: in state Gk with req_k = 1. On that edge:
  - f <= d_k
  - f_valid <= 1
  - cnt <= cnt + 1
- Any non-transfer cycle sets f_valid <= 0 and leaves f unchanged.
- In Gk, next state:
  - req_k = 0: the cycle is a non-transfer cycle. Go to the other grant state if the other side is requesting, else IDLE.
  - Transfer with cnt = MAX_BURST-1 and the other side requesting: switch to the other grant state and clear cnt.
  - Transfer with cnt = MAX_BURST-1 and the other side idle: stay in Gk and clear cnt (the burst restarts).
  - Otherwise: stay in Gk.
- In IDLE, sel holds its last value. f and sel are never cleared except by reset.
- MAX_BURST = 1 with both sides requesting gives strict alternation: 1,2,1,2,...
- cnt is an 8-bit counter and never exceeds MAX_BURST-1.

## Timing
- Reset values:
  - gnt1, gnt2, sel, f (all bits), f_valid: 0.
  - State: IDLE; cnt: 0; `last`: 2.
- Reset asserted mid-burst: on the next edge every output takes its reset value. A transfer in that cycle is discarded.
- Request to grant: a request sampled high in IDLE at edge n gives a grant visible after edge n.
- Grant to data: on each transfer cycle, d_k sampled at edge m appears on f, with f_valid = 1, after edge m. Latency is 1 cycle.
- Burst-limit handover has no bubble: the last transfer of side k and the first transfer of the other side are on consecutive edges.
- Handover caused by req_k falling costs exactly one non-transfer cycle: f_valid = 0 for one cycle.
- A requester must keep d_k stable only on cycles where gnt_k & req_k = 1.
- A request that arrives in the same cycle the other side's burst expires is served on the next edge.

## Test plan
- **Reset mid-burst:** reset, then req1 = 1 with d1 = 8'hA5 held. Expect:
  - gnt1 = 1 after edge 1; f = A5, f_valid = 1 after edge 2.
  - Assert rst at edge 5: all outputs 0 after that edge.
- **Tie after reset:** req1 = req2 = 1 from reset release, MAX_BURST = 4, d1 = 8'h11, d2 = 8'h22. Expect:
  - f carries 11 four times, then 22 four times, then 11 again.
  - f_valid stays high continuously; sel toggles every 4 cycles.
- **Strict alternation:** MAX_BURST = 1, both requesting. Expect f = 11, 22, 11, 22 with f_valid constantly 1.
- **Early release:** req2 = 1 alone for 2 transfers, then req2 = 0 while req1 = 1. Expect:
  - Exactly one cycle with f_valid = 0.
  - Then gnt1 = 1 and d1 data follows.
- **Burst restart with no competitor:** req1 = 1 alone for 10 cycles. Expect:
  - gnt1 stays high and f_valid stays high after the first data cycle.
  - cnt wraps at 3 without any grant drop.
- **Idle return:** both requests drop. Expect:
  - gnt1 = gnt2 = 0 after the next edge, then f_valid = 0.
  - f and sel keep their last values.
